// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the request/grant arbiter:
// FSM state encoding and arbitration mode selectors.
package rr_priority_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/rr_priority_arbiter_prio_enc.sv
// Combinational highest-set-bit encoder over an N-bit vector.
// idx is zero when no bit is set; any flags a non-empty input.
module prio_enc_n #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        // Later iterations overwrite earlier ones, so the top set bit wins.
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                idx = W'(i);
            end
        end
        any = |in;
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Single-resource arbiter with fixed or round-robin priority;
// a grant is held until ack, followed by at least one idle cycle.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [W-1:0]   idx_nxt;
    logic           valid_nxt;

    logic [N-1:0]   enc_in;
    logic [W-1:0]   enc_idx;
    logic           enc_any;
    logic [W-1:0]   win_idx;
    int             k;
    int             s;

    // Round-robin rotates req so that ptr lands on the top bit; the
    // encoder's downward search then starts at ptr and wraps modulo N.
    always_comb begin
        enc_in  = req;
        win_idx = enc_idx;
        k       = 0;
        s       = 0;
        if (MODE == MODE_RR) begin
            for (int j = 0; j < N; j++) begin
                k = j + int'(ptr) + 1;
                if (k >= N) begin
                    k = k - N;
                end
                enc_in[j] = req[k[W-1:0]];
            end
            s = int'(enc_idx) + int'(ptr) + 1;
            if (s >= N) begin
                s = s - N;
            end
            win_idx = s[W-1:0];
        end
    end

    prio_enc_n #(
        .N (N),
        .W (W)
    ) u_enc (
        .in  (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        unique case (state)
            IDLE: begin
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                if (enc_any) begin
                    state_nxt        = GRANT;
                    gnt_nxt[win_idx] = 1'b1;
                    idx_nxt          = win_idx;
                    valid_nxt        = 1'b1;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                    if (MODE == MODE_RR) begin
                        ptr_nxt = (gnt_idx == '0) ? W'(N - 1)
                                                  : gnt_idx - W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= W'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: four instances (N=4/8, both modes)
// checked against a queue scoreboard fed by a behavioural model.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_v [4];
    logic       ack_v [4];

    logic [3:0] g0, g1;
    logic [1:0] i0, i1;
    logic [7:0] g2, g3;
    logic [2:0] i2, i3;
    logic       v0, v1, v2, v3;

    logic [7:0] gnt_o [4];
    logic [2:0] idx_o [4];
    logic       val_o [4];

    int nn [4] = '{4, 4, 8, 8};
    int md [4] = '{0, 1, 0, 1};

    int passed = 0;
    int total  = 0;
    bit mon_en = 0;

    typedef struct {
        int d;
        int w;
    } exp_t;
    exp_t exp_q[$];

    int m_state [4];
    int m_ptr   [4];
    int m_idx   [4];
    int prev_v  [4];

    rr_priority_arbiter #(.N(4), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .req(req_v[0][3:0]), .ack(ack_v[0]),
        .gnt(g0), .gnt_idx(i0), .gnt_valid(v0));
    rr_priority_arbiter #(.N(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .req(req_v[1][3:0]), .ack(ack_v[1]),
        .gnt(g1), .gnt_idx(i1), .gnt_valid(v1));
    rr_priority_arbiter #(.N(8), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .req(req_v[2]), .ack(ack_v[2]),
        .gnt(g2), .gnt_idx(i2), .gnt_valid(v2));
    rr_priority_arbiter #(.N(8), .MODE(1)) u3 (
        .clk(clk), .rst(rst), .req(req_v[3]), .ack(ack_v[3]),
        .gnt(g3), .gnt_idx(i3), .gnt_valid(v3));

    assign gnt_o[0] = {4'b0000, g0};
    assign gnt_o[1] = {4'b0000, g1};
    assign gnt_o[2] = g2;
    assign gnt_o[3] = g3;
    assign idx_o[0] = {1'b0, i0};
    assign idx_o[1] = {1'b0, i1};
    assign idx_o[2] = i2;
    assign idx_o[3] = i3;
    assign val_o[0] = v0;
    assign val_o[1] = v1;
    assign val_o[2] = v2;
    assign val_o[3] = v3;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference winner: scan candidate indices in priority order.
    function automatic int pick(int d, logic [7:0] r);
        int i;
        if (md[d] == 0) begin
            for (i = nn[d] - 1; i >= 0; i--)
                if (r[i]) return i;
        end else begin
            for (int c = 0; c < nn[d]; c++) begin
                i = (m_ptr[d] - c + nn[d]) % nn[d];
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 4; d++) begin
                m_state[d] = 0;
                m_ptr[d]   = nn[d] - 1;
                m_idx[d]   = 0;
            end
            exp_q.delete();
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (m_state[d] == 0) begin
                    if (pick(d, req_v[d]) >= 0) begin
                        m_idx[d]   = pick(d, req_v[d]);
                        m_state[d] = 1;
                        exp_q.push_back('{d, m_idx[d]});
                    end
                end else if (ack_v[d]) begin
                    m_state[d] = 0;
                    if (md[d] == 1)
                        m_ptr[d] = (m_idx[d] + nn[d] - 1) % nn[d];
                    m_idx[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int found;
        int eg;
        if (mon_en) begin
            for (int d = 0; d < 4; d++) begin
                eg = m_state[d] ? (1 << m_idx[d]) : 0;
                check($sformatf("onehot[%0d]", d),
                      int'($countones(gnt_o[d]) <= 1), 1);
                check($sformatf("valid[%0d]", d), int'(val_o[d]), m_state[d]);
                check($sformatf("gnt[%0d]", d), int'(gnt_o[d]), eg);
                if (val_o[d] && prev_v[d] == 0) begin
                    found = 0;
                    for (int q = 0; q < exp_q.size(); q++) begin
                        if (found == 0 && exp_q[q].d == d) begin
                            check($sformatf("sb_idx[%0d]", d),
                                  int'(idx_o[d]), exp_q[q].w);
                            exp_q.delete(q);
                            found = 1;
                        end
                    end
                    check($sformatf("sb_present[%0d]", d), found, 1);
                end
                prev_v[d] = int'(val_o[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set4(logic [3:0] r, logic a);
        req_v[0] = {4'b0000, r};
        req_v[1] = {4'b0000, r};
        ack_v[0] = a;
        ack_v[1] = a;
    endtask

    task automatic exp_out(int d, string nm, int eg, int ei, int ev);
        check({nm, "_gnt"}, int'(gnt_o[d]), eg);
        check({nm, "_idx"}, int'(idx_o[d]), ei);
        check({nm, "_valid"}, int'(val_o[d]), ev);
    endtask

    int seq [7] = '{2, 1, 0, 3, 2, 1, 0};

    initial begin
        rst = 1;
        for (int d = 0; d < 4; d++) begin
            req_v[d]  = '0;
            ack_v[d]  = 0;
            prev_v[d] = 0;
        end
        tick();
        tick();
        for (int d = 0; d < 4; d++) exp_out(d, "reset", 0, 0, 0);
        rst    = 0;
        mon_en = 1;

        set4(4'b1001, 0);
        tick();
        exp_out(0, "m0_grant", 8, 3, 1);
        repeat (5) begin
            tick();
            exp_out(0, "m0_hold", 8, 3, 1);
        end
        set4(4'b1001, 1);
        tick();
        exp_out(0, "m0_release", 0, 0, 0);

        set4(4'b1111, 0);
        tick();
        rst = 1;
        #1;
        exp_out(0, "rst_async0", 0, 0, 0);
        exp_out(1, "rst_async1", 0, 0, 0);
        tick();
        rst = 0;
        tick();
        exp_out(0, "rst_first0", 8, 3, 1);
        exp_out(1, "rst_first1", 8, 3, 1);

        for (int s = 0; s < 7; s++) begin
            set4(4'b1111, 1);
            tick();
            exp_out(1, "rr_gap", 0, 0, 0);
            set4(4'b1111, 0);
            tick();
            exp_out(1, "rr_seq", 1 << seq[s], seq[s], 1);
        end

        set4(4'b0000, 1);
        tick();
        exp_out(1, "wrap_gap", 0, 0, 0);
        set4(4'b0011, 0);
        tick();
        exp_out(1, "wrap_win", 2, 1, 1);

        set4(4'b0000, 1);
        tick();
        set4(4'b0100, 0);
        tick();
        exp_out(1, "hold_grant", 4, 2, 1);
        set4(4'b0000, 0);
        repeat (3) begin
            tick();
            exp_out(1, "withdraw", 4, 2, 1);
        end
        set4(4'b0000, 1);
        tick();
        exp_out(1, "ack_release", 0, 0, 0);
        repeat (2) begin
            tick();
            exp_out(1, "idle_ack", 0, 0, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) begin
                rst = 1;
                tick();
                rst = 0;
            end else begin
                for (int d = 0; d < 4; d++) begin
                    req_v[d] = ($urandom_range(0, 3) == 0) ? 8'h00
                             : 8'($urandom);
                    if (nn[d] == 4) req_v[d] = req_v[d] & 8'h0f;
                    ack_v[d] = ($urandom_range(0, 2) == 0);
                end
                tick();
            end
        end

        for (int d = 0; d < 4; d++) begin
            req_v[d] = '0;
            ack_v[d] = 1;
        end
        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
